// File: rtl/firebird_imm_gen_pipe_pkg.sv
// Shared constants and immediate assembly for the firebird immediate generator.
// Optional feature macro: FIREBIRD_IMM_ILLEGAL_EN (adds out_illegal).
package firebird_imm_gen_pipe_pkg;

    localparam int unsigned INST_W_DEFAULT = 32;
    localparam int unsigned XLEN_DEFAULT   = 32;
    localparam int unsigned FMT_W          = 3;
    localparam int unsigned OPCODE_W       = 7;
    localparam int unsigned IMM_FULL_W     = 64;

    localparam logic [FMT_W-1:0] FMT_R    = 3'd0;
    localparam logic [FMT_W-1:0] FMT_I    = 3'd1;
    localparam logic [FMT_W-1:0] FMT_S    = 3'd2;
    localparam logic [FMT_W-1:0] FMT_B    = 3'd3;
    localparam logic [FMT_W-1:0] FMT_U    = 3'd4;
    localparam logic [FMT_W-1:0] FMT_J    = 3'd5;
    localparam logic [FMT_W-1:0] FMT_NONE = 3'd7;

    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_FENCE  = 7'b0001111;
    localparam logic [OPCODE_W-1:0] OP_SYSTEM = 7'b1110011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_REG    = 7'b0110011;

    // Builds the immediate sign-extended to 64 bits; callers truncate to XLEN.
    function automatic logic [IMM_FULL_W-1:0] assemble_imm(
        input logic [31:0]      inst,
        input logic [FMT_W-1:0] fmt
    );
        logic [IMM_FULL_W-1:0] imm;
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{52{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {{32{inst[31]}}, inst[31:12], 12'b0};
            FMT_J:   imm = {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/firebird_imm_gen_pipe_fmt_dec.sv
// Combinational opcode-to-format classifier used in the first pipeline stage.
module firebird_imm_fmt_dec
    import firebird_imm_gen_pipe_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output logic [FMT_W-1:0]    fmt_c
);

    always_comb begin
        fmt_c = FMT_NONE;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM: fmt_c = FMT_I;
            OP_STORE:                                      fmt_c = FMT_S;
            OP_BRANCH:                                     fmt_c = FMT_B;
            OP_LUI, OP_AUIPC:                              fmt_c = FMT_U;
            OP_JAL:                                        fmt_c = FMT_J;
            OP_REG:                                        fmt_c = FMT_R;
            default:                                       fmt_c = FMT_NONE;
        endcase
    end

endmodule

// File: rtl/firebird_imm_gen_pipe.sv
// Two-stage valid/ready pipeline extracting the sign-extended RV32I immediate.
// Optional: define FIREBIRD_IMM_ILLEGAL_EN to add the out_illegal flag.
module firebird_imm_gen_pipe
    import firebird_imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned INST_W = INST_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_imm,
    output logic [FMT_W-1:0]  out_fmt
`ifdef FIREBIRD_IMM_ILLEGAL_EN
    ,
    output logic              out_illegal
`endif
);

    logic                  s1_valid;
    logic [INST_W-1:0]     s1_inst;
    logic [FMT_W-1:0]      s1_fmt;
    logic [FMT_W-1:0]      dec_fmt_c;
    logic                  s2_load_c;
    logic [IMM_FULL_W-1:0] s1_imm_c;

    // S2 takes new data whenever it is empty or its result is leaving this cycle.
    assign s2_load_c = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load_c;
    assign s1_imm_c  = assemble_imm(s1_inst[31:0], s1_fmt);

    firebird_imm_fmt_dec u_fmt_dec (
        .opcode (in_inst[OPCODE_W-1:0]),
        .fmt_c  (dec_fmt_c)
    );

    // Stage 1: raw instruction plus its decoded format.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_inst  <= '0;
            s1_fmt   <= FMT_R;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_inst <= in_inst;
                s1_fmt  <= dec_fmt_c;
            end
        end
    end

    // Stage 2: assembled immediate; payload only changes on a real load so it holds under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_imm   <= '0;
            out_fmt   <= FMT_R;
        end else if (s2_load_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_imm <= XLEN'(s1_imm_c);
                out_fmt <= s1_fmt;
            end
        end
    end

`ifdef FIREBIRD_IMM_ILLEGAL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_illegal <= 1'b0;
        end else if (s2_load_c && s1_valid) begin
            out_illegal <= (s1_fmt == FMT_NONE);
        end
    end
`endif

endmodule

// File: tb/tb_firebird_imm_gen_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances driven in lockstep against a reference model.
module tb_firebird_imm_gen_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_inst;
    logic        in_ready, out_valid, in_ready64, out_valid64;
    logic [31:0] out_imm;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt, out_fmt64;
`ifdef FIREBIRD_IMM_ILLEGAL_EN
    logic        out_illegal, out_illegal64;
`endif

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23,
                             7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

    always #5 clk = ~clk;

    firebird_imm_gen_pipe #(.XLEN(32), .INST_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt)
`ifdef FIREBIRD_IMM_ILLEGAL_EN
        , .out_illegal(out_illegal)
`endif
    );

    firebird_imm_gen_pipe #(.XLEN(64), .INST_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .in_inst(in_inst), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64)
`ifdef FIREBIRD_IMM_ILLEGAL_EN
        , .out_illegal(out_illegal64)
`endif
    );

    // Reference: immediate computed with signed shifts on the whole word.
    function automatic exp_t model(input logic [31:0] inst);
        exp_t   e;
        longint si;
        si = $signed(inst);
        case (inst[6:0])
            7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: begin e.fmt = 3'd1; e.imm = si >>> 20; end
            7'h23: begin
                e.fmt = 3'd2;
                e.imm = ((si >>> 25) << 5) | longint'(inst[11:7]);
            end
            7'h63: begin
                e.fmt = 3'd3;
                e.imm = ((si >>> 31) << 12) | (longint'(inst[7]) << 11)
                      | (longint'(inst[30:25]) << 5) | (longint'(inst[11:8]) << 1);
            end
            7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = (si >>> 12) << 12; end
            7'h6F: begin
                e.fmt = 3'd5;
                e.imm = ((si >>> 31) << 20) | (longint'(inst[19:12]) << 12)
                      | (longint'(inst[20]) << 11) | (longint'(inst[30:21]) << 1);
            end
            7'h33:   begin e.fmt = 3'd0; e.imm = 64'd0; end
            default: begin e.fmt = 3'd7; e.imm = 64'd0; end
        endcase
        return e;
    endfunction

    task automatic test_reset();
        #3;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_imm !== 32'd0 || out_fmt !== 3'd0
            || out_valid64 !== 1'b0 || out_imm64 !== 64'd0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b imm=%h fmt=%0d v64=%b imm64=%h, want 1 0 0 0 0 0",
                     in_ready, out_valid, out_imm, out_fmt, out_valid64, out_imm64);
        end
`ifdef FIREBIRD_IMM_ILLEGAL_EN
        checks++;
        if (out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_illegal: got %b want 0", out_illegal);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] vi [8] = '{32'hFFF00093, 32'h00112623, 32'hFE000EE3, 32'h12345037,
                                32'hFF9FF06F, 32'h80000037, 32'h0000007F, 32'h00000033};
        logic [63:0] vimm [8] = '{64'hFFFFFFFFFFFFFFFF, 64'h000000000000000C, 64'hFFFFFFFFFFFFFFFC,
                                  64'h0000000012345000, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFF80000000,
                                  64'h0, 64'h0};
        logic [2:0]  vfmt [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd7, 3'd0};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_inst   = vi[i];
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir_in_ready[%0d]: got %b want 1", i, in_ready);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dir_early_valid[%0d]: got %b want 0", i, out_valid);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_imm !== vimm[i][31:0] || out_fmt !== vfmt[i]
                || out_imm64 !== vimm[i] || out_fmt64 !== vfmt[i]) begin
                errors++;
                $display("FAIL dir_result[%0d] inst=%h: valid=%b imm=%h fmt=%0d imm64=%h, want 1 %h %0d %h",
                         i, vi[i], out_valid, out_imm, out_fmt, out_imm64, vimm[i][31:0], vfmt[i], vimm[i]);
            end
`ifdef FIREBIRD_IMM_ILLEGAL_EN
            checks++;
            if (out_illegal !== (vfmt[i] == 3'd7) || out_illegal64 !== (vfmt[i] == 3'd7)) begin
                errors++;
                $display("FAIL dir_illegal[%0d]: got %b/%b want %b", i, out_illegal, out_illegal64,
                         vfmt[i] == 3'd7);
            end
`endif
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] insts [8];
        logic [31:0] r, h_imm;
        logic [2:0]  h_fmt;
        logic        held = 1'b0, drop = 1'b0;
        int          sent = 0, got = 0, cyc = 0;
        exp_t        e;
        for (int i = 0; i < 8; i++) begin
            r = $urandom();
            insts[i] = {r[31:7], ops[$urandom_range(0, 11)]};
        end
        q.delete();
        while (got < 8 && cyc < 60) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 3 && cyc < 6);
            in_valid  = (sent < 8);
            in_inst   = insts[sent % 8];
            #1;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_imm !== h_imm || out_fmt !== h_fmt) begin
                    errors++;
                    $display("FAIL b2b_hold: valid=%b imm=%h fmt=%0d, want 1 %h %0d",
                             out_valid, out_imm, out_fmt, h_imm, h_fmt);
                end
            end
            held  = out_valid && !out_ready;
            h_imm = out_imm;
            h_fmt = out_fmt;
            if (!in_ready) drop = 1'b1;
            if (in_valid && in_ready) begin
                q.push_back(model(in_inst));
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious: output %h with nothing expected", out_imm);
                end else begin
                    e = q.pop_front();
                    if (out_imm !== e.imm[31:0] || out_fmt !== e.fmt || out_imm64 !== e.imm) begin
                        errors++;
                        $display("FAIL b2b_data[%0d]: imm=%h fmt=%0d imm64=%h, want %h %0d %h",
                                 got, out_imm, out_fmt, out_imm64, e.imm[31:0], e.fmt, e.imm);
                    end
                end
                got++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 8 || sent != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d sent %0d, want 8 8", got, sent);
        end
        checks++;
        if (!drop) begin
            errors++;
            $display("FAIL b2b_in_ready_drop: got no drop, want drop during stall");
        end
        @(posedge clk); #2;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_duplicate: out_valid=%b after stream, want 0", out_valid);
        end
    endtask

    task automatic test_random_stream();
        logic [31:0] r, h_imm;
        logic [2:0]  h_fmt;
        logic        held = 1'b0;
        int          sent = 0, got = 0;
        exp_t        e;
        q.delete();
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk); #1;
            out_ready = (cyc >= 250) || ($urandom_range(0, 3) != 0);
            in_valid  = (cyc < 250) && ($urandom_range(0, 3) != 0);
            r = $urandom();
            in_inst = {r[31:7], ops[$urandom_range(0, 11)]};
            #1;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_imm !== h_imm || out_fmt !== h_fmt) begin
                    errors++;
                    $display("FAIL rnd_hold: valid=%b imm=%h fmt=%0d, want 1 %h %0d",
                             out_valid, out_imm, out_fmt, h_imm, h_fmt);
                end
            end
            held  = out_valid && !out_ready;
            h_imm = out_imm;
            h_fmt = out_fmt;
            if (in_valid && in_ready) begin
                q.push_back(model(in_inst));
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious: output %h with nothing expected", out_imm);
                end else begin
                    e = q.pop_front();
                    if (out_imm !== e.imm[31:0] || out_fmt !== e.fmt || out_imm64 !== e.imm
                        || out_valid64 !== 1'b1) begin
                        errors++;
                        $display("FAIL rnd_data[%0d]: imm=%h fmt=%0d imm64=%h v64=%b, want %h %0d %h 1",
                                 got, out_imm, out_fmt, out_imm64, out_valid64, e.imm[31:0], e.fmt, e.imm);
                    end
`ifdef FIREBIRD_IMM_ILLEGAL_EN
                    if (out_illegal !== (e.fmt == 3'd7)) begin
                        errors++;
                        $display("FAIL rnd_illegal[%0d]: got %b want %b", got, out_illegal, e.fmt == 3'd7);
                    end
`endif
                end
                got++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (q.size() != 0 || got != sent) begin
            errors++;
            $display("FAIL rnd_drain: got %0d of %0d, %0d left", got, sent, q.size());
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_inst  = {$urandom_range(0, 255), 24'h000013};
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_full: out_valid=%b in_ready=%b, want 1 0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 32'd0 || out_valid64 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: out_valid=%b in_ready=%b imm=%h v64=%b, want 0 1 0 0",
                     out_valid, in_ready, out_imm, out_valid64);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inst   = 32'h12345037;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_early: out_valid=%b want 0", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_imm !== 32'h12345000 || out_fmt !== 3'd4) begin
            errors++;
            $display("FAIL rstmid_after: valid=%b imm=%h fmt=%0d, want 1 12345000 4",
                     out_valid, out_imm, out_fmt);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_stale: out_valid=%b want 0 (old data discarded)", out_valid);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_inst   = 32'd0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random_stream();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
